// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NREQ requesters in bursts of up to BURST words.
// Define FIFO_ARB_PRIO_EN to give requester 0 fixed priority and pre-emption rights.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   sel_idx;
    logic            sel_vld;
    logic            release_now;
    int              idx;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Owner index, plus the first requester at or above rr_ptr (modulo NREQ).
    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        g_idx   = '0;
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) g_idx = PW'(i);
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req[idx]) begin
                sel_vld = 1'b1;
                sel_idx = PW'(idx);
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        if (req[0]) begin
            sel_vld = 1'b1;
            sel_idx = '0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d          = GRANT;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    busy_d           = 1'b1;
                    beat_cnt_d       = '0;
                end
            end
            GRANT: begin
                beat_cnt_d  = beat_cnt_q + 8'(winc);
                release_now = (winc && (beat_cnt_q == 8'(BURST - 1))) || !req[g_idx];
                if (release_now) begin
                    rr_ptr_d = (int'(g_idx) == NREQ - 1) ? '0 : g_idx + PW'(1);
                end
`ifdef FIFO_ARB_PRIO_EN
                // Pre-emption by port 0 keeps rr_ptr so the interrupted rotation resumes.
                if (!release_now && req[0] && (g_idx != '0) && (winc || (beat_cnt_q != '0))) begin
                    release_now = 1'b1;
                end
`endif
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // grant_q is all-zero in IDLE, so the OR-mux drives wdata to 0 there.
    always_comb begin
        winc  = busy_q & req[g_idx] & ~wfull;
        ack   = winc ? grant_q : '0;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) wdata = req_data[i*DSIZE +: DSIZE];
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Table-driven bench for fifo_wr_arb (default build, NREQ=4, DSIZE=8, BURST=4) with a write-data scoreboard.
module tb_fifo_wr_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_push = 0;
    int n_pop  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       wfull;
        logic [3:0] grant;
        logic       winc;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    fifo_wr_arb #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .wfull    (wfull),
        .ack      (ack),
        .grant    (grant),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] q, input logic f,
                                input logic [3:0] g, input logic w);
        vec_t v;
        v.rst = r; v.req = q; v.wfull = f; v.grant = g; v.winc = w;
        vecs.push_back(v);
    endfunction

    function automatic logic [7:0] slice_of(input logic [31:0] d, input logic [3:0] g);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) if (g[i]) s = d[i*8 +: 8];
        return s;
    endfunction

    // Scoreboard drain: every DUT write must match the oldest expected word.
    task automatic sb_pop(input string name);
        logic [7:0] e;
        if (winc) begin
            n_pop++;
            if (sb.size() == 0) begin
                check({name, "_unexpected_write"}, 32'(winc), 32'd0);
            end else begin
                e = sb.pop_front();
                check({name, "_sb_wdata"}, 32'(wdata), 32'(e));
            end
        end
    endtask

    initial begin
        bit got_busy;

        // Single-port burst, one idle cycle, regrant to the same port.
        add(0, 4'b0100, 0, 4'b0000, 0);
        repeat (4) add(0, 4'b0100, 0, 4'b0100, 1);
        add(0, 4'b0100, 0, 4'b0000, 0);
        add(0, 4'b0100, 0, 4'b0100, 1);
        add(0, 4'b0000, 0, 4'b0100, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(1, 4'b0000, 0, 4'b0000, 0);
        // All ports requesting: rotation 0,1,2,3,0,1 with 4-on/1-off writes.
        for (int b = 0; b < 6; b++) begin
            add(0, 4'b1111, 0, 4'b0000, 0);
            repeat (4) add(0, 4'b1111, 0, 4'(1 << (b % 4)), 1);
        end
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(1, 4'b0000, 0, 4'b0000, 0);
        // Port 1 stalled by wfull after 2 words; others toggle without effect.
        add(0, 4'b0010, 0, 4'b0000, 0);
        repeat (2) add(0, 4'b0010, 0, 4'b0010, 1);
        repeat (5) add(0, 4'b1111, 1, 4'b0010, 0);
        repeat (2) add(0, 4'b0010, 0, 4'b0010, 1);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // Port 3 drops after 2 words; rr_ptr wraps to 0.
        add(0, 4'b1000, 0, 4'b0000, 0);
        repeat (2) add(0, 4'b1000, 0, 4'b1000, 1);
        add(0, 4'b0001, 0, 4'b1000, 0);
        add(0, 4'b0001, 0, 4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, 1);
        add(0, 4'b0000, 0, 4'b0001, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // Reset during the third word of port 2's burst.
        add(0, 4'b0100, 0, 4'b0000, 0);
        repeat (2) add(0, 4'b0100, 0, 4'b0100, 1);
        add(1, 4'b0100, 0, 4'b0100, 1);
        add(0, 4'b1111, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 1);
        add(0, 4'b0000, 0, 4'b0001, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // Request while FIFO full: grant still arrives, writes wait for wfull low.
        add(0, 4'b0010, 1, 4'b0000, 0);
        add(0, 4'b0010, 1, 4'b0010, 0);
        add(0, 4'b0010, 0, 4'b0010, 1);
        add(0, 4'b0000, 0, 4'b0010, 0);
        add(0, 4'b0000, 1, 4'b0000, 0);

        rst      = 1'b1;
        req      = '0;
        wfull    = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            rst   = vecs[k].rst;
            req   = vecs[k].req;
            wfull = vecs[k].wfull;
            @(negedge clk);
            check($sformatf("row%0d_grant", k), 32'(grant), 32'(vecs[k].grant));
            check($sformatf("row%0d_busy", k),  32'(busy),  32'(|vecs[k].grant));
            check($sformatf("row%0d_winc", k),  32'(winc),  32'(vecs[k].winc));
            check($sformatf("row%0d_ack", k),   32'(ack),   32'(vecs[k].winc ? vecs[k].grant : 4'b0000));
            check($sformatf("row%0d_wdata", k), 32'(wdata), 32'(slice_of(req_data, vecs[k].grant)));
            if (vecs[k].winc) begin
                sb.push_back(slice_of(req_data, vecs[k].grant));
                n_push++;
            end
            sb_pop($sformatf("row%0d", k));
        end

        // wdata must follow the granted slice combinationally, even while stalled.
        @(posedge clk); #1;
        rst = 1'b1; req = 4'b0000; wfull = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b0100;
        got_busy = 1'b0;
        for (int c = 0; c < 4 && !got_busy; c++) begin
            @(negedge clk);
            if (busy) got_busy = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("seq_busy_wait", 32'(got_busy), 32'd1);
        check("seq_grant", 32'(grant), 32'(4'b0100));
        for (int c = 0; c < 3; c++) begin
            req_data = $urandom;
            #1;
            check($sformatf("seq%0d_wdata", c), 32'(wdata), 32'(req_data[23:16]));
            check($sformatf("seq%0d_ack", c), 32'(ack), 32'(4'b0100));
            sb.push_back(req_data[23:16]);
            n_push++;
            sb_pop($sformatf("seq%0d", c));
            @(posedge clk); #1;
        end
        wfull    = 1'b1;
        req_data = $urandom;
        @(negedge clk);
        check("seq_full_winc", 32'(winc), 32'd0);
        check("seq_full_wdata", 32'(wdata), 32'(req_data[23:16]));
        check("seq_full_grant", 32'(grant), 32'(4'b0100));
        @(posedge clk); #1;
        wfull = 1'b0;
        @(negedge clk);
        check("seq_last_word_winc", 32'(winc), 32'd1);
        sb.push_back(req_data[23:16]);
        n_push++;
        sb_pop("seq_last");
        @(posedge clk); #1;
        req = 4'b0000;
        @(negedge clk);
        check("seq_release_grant", 32'(grant), 32'd0);
        check("seq_release_wdata", 32'(wdata), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("write_count", 32'(n_pop), 32'(n_push));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DSIZE, default 8: data word width; SHALL equal the FIFO data width.
REQ-003 Parameter BURST, default 4: maximum words accepted per grant (1..255).
REQ-004 clk  input  1  single clock; the write side of the FIFO runs on this clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester valid; bit i high means word req_data[i] is offered.
REQ-007 req_data  input  NREQ*DSIZE  packed requester data, slice i = bits [i*DSIZE +: DSIZE].
REQ-008 wfull  input  1  FIFO write-full flag.
REQ-009 ack  output  NREQ  one-hot; bit i high means requester i's word is written this cycle.
REQ-010 grant  output  NREQ  one-hot current owner; all-zero when idle.
REQ-011 winc  output  1  FIFO write enable.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 busy  output  1  high while in state GRANT.

Function
REQ-014 FSM states: IDLE and GRANT only.
REQ-015 IDLE: if any req bit is high, select the first set bit searching upward (modulo NREQ) from rr_ptr, register it into grant, clear beat_cnt and go to GRANT next cycle; otherwise stay in IDLE.
REQ-016 grant, busy and FSM state SHALL be registered; winc, wdata and ack SHALL be combinational from grant, req, req_data and wfull.
REQ-017 winc = busy AND req[g] AND NOT wfull, where g is the granted index; wdata = req_data slice g at all times in GRANT, and 0 in IDLE.
REQ-018 ack[g] = winc; all other ack bits = 0; ack is all-zero in IDLE.
REQ-019 beat_cnt (8 bits) SHALL increment on every cycle with winc high.
REQ-020 GRANT -> IDLE on the cycle where (winc AND beat_cnt == BURST-1) or req[g] is low; grant clears and rr_ptr = (g+1) mod NREQ at that edge.
REQ-021 While wfull is high in GRANT: grant is held, winc = 0, beat_cnt frozen, and no timeout is applied.
REQ-022 Every release is followed by exactly one IDLE cycle; a continuously requesting port therefore writes at most BURST words per BURST+1 cycles.
REQ-023 Latency: req rising in IDLE at cycle N -> grant at N+1 -> first winc at N+1 if wfull is low.
REQ-024 Fairness: with all ports requesting, grants rotate 0,1,...,NREQ-1,0; no port waits more than (NREQ-1)*(BURST+1) cycles while the FIFO is not full.
REQ-025 Changes on non-granted req bits SHALL NOT affect the current grant.

Reset
REQ-026 With rst high at a clk edge: state=IDLE, grant=0, busy=0, beat_cnt=0, rr_ptr=0; winc=0, ack=0 and wdata=0 follow combinationally.
REQ-027 Reset asserted mid-burst SHALL abort the burst at that edge with no further winc; already-written words are not revoked.

Configuration
REQ-028 Macro FIFO_ARB_PRIO_EN defined: in IDLE, requester 0 is selected whenever req[0] is high, regardless of rr_ptr; in GRANT, requester 0 pre-empts the current owner (release at that edge, as in REQ-020, rr_ptr unchanged) once the owner has written at least one word.
REQ-029 Macro FIFO_ARB_PRIO_EN undefined: pure round-robin as in REQ-015 and REQ-020; no priority logic is synthesised.

Verification
REQ-030 Reset, then req=4'b0100 held and wfull=0 -> grant=4'b0100 after 1 cycle; 4 consecutive winc; IDLE for 1 cycle; regrant to port 2.
REQ-031 req=4'b1111 held for 30 cycles, wfull=0 -> grant order 0,1,2,3,0,1; each burst is 4 words; winc pattern is 4 on, 1 off.
REQ-032 Port 1 granted; wfull=1 for 5 cycles after the 2nd word -> winc=0 and grant held for 5 cycles; words 3-4 then complete; total ack[1] count = 4.
REQ-033 Port 3 granted; req[3] drops after 2 words -> release in the same cycle; rr_ptr=0; next grant goes to port 0 if it is requesting.
REQ-034 rst pulsed for 1 cycle during the 3rd word of a burst -> grant=0 and winc=0 from the next cycle; the next grant starts search at port 0.
REQ-035 With FIFO_ARB_PRIO_EN, port 2 mid-burst and req[0] rising -> port 2 released after its current word; port 0 granted after 1 IDLE cycle.
